// File: rtl/fetch_ifid_stage_pkg.sv
// Shared definitions for the fetch stage and the IF/ID register.
// The hazard unit imports the same package, so it decodes register fields
// from IF/ID at the same bit positions that this stage exports.
package fetch_ifid_stage_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding at pc
        ST_HOLD  = 2'd1,  // one instruction buffered, no request
        ST_DROP  = 2'd2   // request outstanding whose data will be thrown away
    } fetch_state_e;

    // Encoding loaded into IF/ID as a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Register-field positions inside an instruction word.
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

endpackage

// File: rtl/fetch_ifid_stage_ifid_reg.sv
// IF/ID pipeline register with bubble and hold controls.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bubble_i    load {NOP, 0, invalid}; overrides everything else
//   hold_i      keep current contents
//   load_i      capture instr_i/pc4_i as a valid instruction
//   instr_i     instruction word to capture
//   pc4_i       PC+4 of that instruction
//   instr_o     registered instruction
//   pc4_o       registered PC+4
//   valid_o     register holds a real instruction
module ifid_reg #(
    parameter int              AW  = 32,
    parameter int              IW  = 32,
    parameter logic [IW-1:0]   NOP = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bubble_i,
    input  logic          hold_i,
    input  logic          load_i,
    input  logic [IW-1:0] instr_i,
    input  logic [AW-1:0] pc4_i,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] pc4_o,
    output logic          valid_o
);

    logic [IW-1:0] instr_q;
    logic [AW-1:0] pc4_q;
    logic          valid_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            instr_q <= instr_q;
            pc4_q   <= pc4_q;
            valid_q <= valid_q;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage plus IF/ID register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   Stall, Flush         hazard-unit controls (freeze / bubble IF/ID)
//   BranchTaken/Target   fetch redirect
//   imem_req/addr        request to instruction memory, held until imem_ack
//   imem_ack/rdata       response; ack may come in the same cycle as req
//   IfId_Instr/Pc4/Valid IF/ID contents
//   IfIdRs, IfIdRt       register fields of IfId_Instr for the hazard unit
//   stall_cnt            saturating count of cycles with Stall=1
module fetch_ifid_stage
    import fetch_ifid_stage_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            IW       = 32,
    parameter logic [AW-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [IW-1:0] NOP      = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          BranchTaken,
    input  logic [AW-1:0] BranchTarget,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] IfId_Instr,
    output logic [AW-1:0] IfId_Pc4,
    output logic          IfId_Valid,
    output logic [4:0]    IfIdRs,
    output logic [4:0]    IfIdRt,
    output logic [15:0]   stall_cnt
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] buf_instr_q, buf_instr_d;
    logic [AW-1:0] buf_pc4_q, buf_pc4_d;
    logic [AW-1:0] saved_q, saved_d;
    logic          started_q;
    logic [15:0]   stall_cnt_q;

    logic          ack_v;
    logic [AW-1:0] pc_plus4;
    logic          load_c;
    logic [IW-1:0] load_instr_c;
    logic [AW-1:0] load_pc4_c;

    // started_q keeps imem_req low in the cycle reset is released, so the
    // first request appears one cycle later and a late ack from a request
    // abandoned by reset is never accepted.
    assign imem_req  = started_q && (state_q != ST_HOLD);
    assign imem_addr = pc_q;
    assign ack_v     = imem_req && imem_ack;
    assign pc_plus4  = pc_q + AW'(4);

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        saved_d      = saved_q;
        load_c       = 1'b0;
        load_instr_c = imem_rdata;
        load_pc4_c   = pc_plus4;

        unique case (state_q)
            ST_FETCH: begin
                if (ack_v) begin
                    if (BranchTaken) begin
                        pc_d = BranchTarget;
                    end else begin
                        pc_d = pc_plus4;
                        // IF/ID cannot take the word this cycle: park it.
                        if (Stall || Flush) begin
                            buf_instr_d = imem_rdata;
                            buf_pc4_d   = pc_plus4;
                            state_d     = ST_HOLD;
                        end else begin
                            load_c = 1'b1;
                        end
                    end
                end else if (BranchTaken) begin
                    // Address must stay stable until the pending ack.
                    saved_d = BranchTarget;
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (BranchTaken) begin
                    pc_d    = BranchTarget;
                    state_d = ST_FETCH;
                end else if (!Stall && !Flush) begin
                    load_c       = 1'b1;
                    load_instr_c = buf_instr_q;
                    load_pc4_c   = buf_pc4_q;
                    state_d      = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (ack_v) begin
                    pc_d    = BranchTaken ? BranchTarget : saved_q;
                    state_d = ST_FETCH;
                end else if (BranchTaken) begin
                    saved_d = BranchTarget;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // NOTE: the one-entry hold buffer is reset along with the control
    // state; it is a single register, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc4_q   <= '0;
            saved_q     <= '0;
            started_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= started_q ? state_d : ST_FETCH;
            pc_q        <= started_q ? pc_d    : pc_q;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            saved_q     <= started_q ? saved_d : saved_q;
            started_q   <= 1'b1;
            if (Stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    ifid_reg #(
        .AW  (AW),
        .IW  (IW),
        .NOP (NOP)
    ) u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (BranchTaken || Flush),
        .hold_i   (Stall),
        .load_i   (load_c),
        .instr_i  (load_instr_c),
        .pc4_i    (load_pc4_c),
        .instr_o  (IfId_Instr),
        .pc4_o    (IfId_Pc4),
        .valid_o  (IfId_Valid)
    );

    assign IfIdRs    = IfId_Instr[RS_MSB:RS_LSB];
    assign IfIdRt    = IfId_Instr[RT_MSB:RT_LSB];
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage plus the IF/ID pipeline register. It is the direct consumer of the hazard unit's Stall and Flush outputs and the producer of the IfIdRs/IfIdRt fields that unit compares against.
- Holds the PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Redirects the PC on taken branches.
- Freezes IF/ID on Stall and inserts a bubble on Flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
AW, 32, PC/address width
IW, 32, instruction width
NOP, 32'h0000_0000, encoding inserted into IF/ID as a bubble

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
Stall  in  1  from hazard unit; freeze PC advance and IF/ID
Flush  in  1  from hazard unit; replace IF/ID contents with bubble
BranchTaken  in  1  branch resolved taken; redirect fetch
BranchTarget  in  AW  redirect address, valid with BranchTaken
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  AW  fetch address, equals pc while imem_req=1
imem_ack  in  1  read data valid this cycle; may arrive in the same cycle as imem_req
imem_rdata  in  IW  instruction word, valid with imem_ack
IfId_Instr  out  IW  IF/ID instruction
IfId_Pc4  out  AW  IF/ID PC+4
IfId_Valid  out  1  IF/ID holds a real instruction
IfIdRs  out  5  IfId_Instr[25:21], combinational
IfIdRt  out  5  IfId_Instr[20:16], combinational
stall_cnt  out  16  count of cycles with Stall=1, saturating

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=FETCH; imem_req=0.
  - IfId_Instr=NOP; IfId_Pc4=0; IfId_Valid=0; stall_cnt=0.
  - Hold buffer cleared; saved target=0.
  - First request is issued in the first cycle after rst_n rises.
  - Reset mid-transaction abandons it; a late imem_ack is ignored until a new request is issued.
- States: FETCH (imem_req=1), HOLD (instruction buffered, imem_req=0), DROP (imem_req=1, waiting to discard a stale response).
- FETCH:
  - ack & !Stall & !BranchTaken: IF/ID <= {imem_rdata, pc+4, 1}; pc <= pc+4. Throughput is 1 instruction/cycle with same-cycle ack.
  - ack & Stall & !BranchTaken: buffer <= {imem_rdata, pc+4}; pc <= pc+4; go to HOLD; IF/ID unchanged.
  - No ack & BranchTaken: saved <= BranchTarget; go to DROP. imem_addr stays stable until ack.
  - ack & BranchTaken: discard the data; pc <= BranchTarget; stay in FETCH.
  - No ack & no redirect: hold pc and imem_addr.
- HOLD:
  - !Stall: IF/ID <= buffer with Valid=1; go to FETCH.
  - BranchTaken (any Stall value): discard the buffer; pc <= BranchTarget; go to FETCH.
- DROP:
  - On ack: discard the data; pc <= saved; go to FETCH.
  - BranchTaken while in DROP: overwrite saved (the last redirect wins).
- IF/ID update priority, highest first:
  1. BranchTaken or Flush: IF/ID <= {NOP, 0, 0}.
  2. Stall: hold.
  3. Load per the state rules above.
- Flush without BranchTaken:
  - Clears IF/ID only.
  - A response arriving that cycle is not lost: it goes to the buffer (HOLD) and loads next cycle unless Stall.
- Stall & Flush together: Flush wins for IF/ID; the PC/buffer rules still follow Stall.
- imem_addr is registered pc; it never changes while imem_req=1 and ack has not been seen.
- stall_cnt increments every cycle Stall=1 and saturates at 16'hFFFF (no wrap).
- pc+4 wraps modulo 2^AW.

Decomposition:
- Shared package holds:
  - FSM state encoding: FETCH=2'd0, HOLD=2'd1, DROP=2'd2.
  - NOP constant.
  - RS_MSB/RS_LSB and RT_MSB/RT_LSB field positions, shared with the hazard unit.
- One sub-module, ifid_reg: the IF/ID register with hold/bubble controls.
- The FSM and PC logic live in the top module.

Test Plan:
- Reset release with a memory that acks in the same cycle, returning 0x11,0x22,0x33 → imem_addr 0,4,8 on consecutive cycles; IF/ID shows 0x11/Pc4=4, then 0x22/8, 0x33/12, with Valid=1.
- Stall high for 3 cycles while the ack arrives at addr 8 → IF/ID holds 0x22; state is HOLD; stall_cnt=3; 0x33 loads in the first cycle after Stall falls; next imem_addr=12.
- BranchTaken with BranchTarget=0x100, with a 2-cycle memory latency and the request at 0x10 outstanding → DROP; the 0x10 data is discarded; the next request is at 0x100; IF/ID shows a bubble (NOP, Valid=0).
- Flush alone while IF/ID=0x22 and an ack returns 0x33 → IF/ID bubble for one cycle, then 0x33 loads; no address is skipped or repeated.
- Stall & Flush together → IF/ID=NOP with Valid=0; pc unchanged; stall_cnt increments.
- Hold Stall for 70000 cycles → stall_cnt saturates at 0xFFFF; drop rst_n mid-wait → all outputs return to reset values immediately (asynchronously).
